line_buffer_3x3: RTL and testbench

LINE_BUFFER_3X3 -- requirements
Module: line_buffer_3x3

---
 rtl/line_buffer_3x3_if.sv | 37 +++
 rtl/line_buffer_3x3.sv | 152 +++++++++++++++
 tb/tb_line_buffer_3x3.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/line_buffer_3x3_if.sv
// Pixel-stream / 3x3-window bundle for line_buffer_3x3.
// oFrameDone is present only when LB_FRAME_DONE_EN is defined.
interface line_buffer_3x3_if #(
  parameter int WI = 8
);
  // iInValid qualifies iPixel. There is no ready: every cycle with iInValid=1
  // transfers one pixel. oOutValid qualifies the three window rows for one cycle.
  logic                 iInValid;
  logic signed [WI-1:0] iPixel;
  logic                 oOutValid;
  logic [3*WI-1:0]      oWindowOutRow1;
  logic [3*WI-1:0]      oWindowOutRow2;
  logic [3*WI-1:0]      oWindowOutRow3;
`ifdef LB_FRAME_DONE_EN
  logic                 oFrameDone;

  modport master (
    output iInValid, iPixel,
    input  oOutValid, oWindowOutRow1, oWindowOutRow2, oWindowOutRow3, oFrameDone
  );

  modport slave (
    input  iInValid, iPixel,
    output oOutValid, oWindowOutRow1, oWindowOutRow2, oWindowOutRow3, oFrameDone
  );
`else
  modport master (
    output iInValid, iPixel,
    input  oOutValid, oWindowOutRow1, oWindowOutRow2, oWindowOutRow3
  );

  modport slave (
    input  iInValid, iPixel,
    output oOutValid, oWindowOutRow1, oWindowOutRow2, oWindowOutRow3
  );
`endif
endinterface

// File: rtl/line_buffer_3x3.sv
// line_buffer_3x3: raster pixels pass through two line memories into a 3x3
// register window. Defining LB_FRAME_DONE_EN adds the one-cycle oFrameDone pulse.
module line_buffer_3x3 #(
  parameter int WI    = 8,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic             iClk,
  input  logic             iRst,
  line_buffer_3x3_if.slave bus,
  output logic [0:0]       dbg_state
);

  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 2;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 2;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  // Line memories: lb1 holds row r-1, lb2 holds row r-2, indexed by column.
  logic signed [WI-1:0] lb1_mem [IMG_W];
  logic signed [WI-1:0] lb2_mem [IMG_W];
  logic signed [WI-1:0] lb1_rd;
  logic signed [WI-1:0] lb2_rd;

  logic [CW-1:0]        col_q, col_d;
  logic [RW-1:0]        row_q, row_d;
  logic [0:0]           state_q, state_d;
  logic signed [WI-1:0] win_q [3][3];
  logic signed [WI-1:0] win_d [3][3];
  logic                 valid_q, valid_d;
  logic [3*WI-1:0]      row1_q, row1_d;
  logic [3*WI-1:0]      row2_q, row2_d;
  logic [3*WI-1:0]      row3_q, row3_d;

  logic accept;
  logic col_end;
  logic frame_end;
  logic win_ok;

  assign accept = bus.iInValid;
  assign lb1_rd = lb1_mem[col_q];
  assign lb2_rd = lb2_mem[col_q];

  always_comb begin
    col_end   = (col_q == COL_LAST);
    frame_end = col_end && (row_q == ROW_LAST);
    win_ok    = (state_q == ST_RUN) && (row_q >= ROW_TWO) && (col_q >= COL_TWO);
  end

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    state_d = state_q;
    win_d   = win_q;
    valid_d = 1'b0;
    row1_d  = row1_q;
    row2_d  = row2_q;
    row3_d  = row3_q;

    if (accept) begin
      col_d = col_end ? '0 : col_q + 1'b1;
      if (col_end) begin
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end

      case (state_q)
        ST_FILL: if (col_end && (row_q == ROW_ONE)) state_d = ST_RUN;
        ST_RUN:  if (frame_end) state_d = ST_FILL;
        default: state_d = ST_FILL;
      endcase

      // Window [row][col]: row 0 = top (oldest line), col 0 = left (oldest column).
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb2_rd;
      win_d[1][2] = lb1_rd;
      win_d[2][2] = bus.iPixel;

      // Output registers only load on a complete window so they hold otherwise.
      if (win_ok) begin
        valid_d = 1'b1;
        row1_d  = {win_d[0][0], win_d[0][1], win_d[0][2]};
        row2_d  = {win_d[1][0], win_d[1][1], win_d[1][2]};
        row3_d  = {win_d[2][0], win_d[2][1], win_d[2][2]};
      end
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= ST_FILL;
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      row1_q  <= '0;
      row2_q  <= '0;
      row3_q  <= '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      row1_q  <= row1_d;
      row2_q  <= row2_d;
      row3_q  <= row3_d;
      win_q   <= win_d;
    end
  end

  // Line memories carry no reset; rows 0 and 1 of every frame overwrite them
  // before any window can read them.
  always_ff @(posedge iClk) begin
    if (accept) begin
      lb2_mem[col_q] <= lb1_rd;
      lb1_mem[col_q] <= bus.iPixel;
    end
  end

  assign bus.oOutValid      = valid_q;
  assign bus.oWindowOutRow1 = row1_q;
  assign bus.oWindowOutRow2 = row2_q;
  assign bus.oWindowOutRow3 = row3_q;
  assign dbg_state          = state_q;

`ifdef LB_FRAME_DONE_EN
  logic frame_done_q, frame_done_d;

  always_comb frame_done_d = accept && frame_end;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) frame_done_q <= 1'b0;
    else      frame_done_q <= frame_done_d;
  end

  assign bus.oFrameDone = frame_done_q;
`endif

endmodule

// File: tb/tb_line_buffer_3x3.sv
// Bench for line_buffer_3x3 on a 5x4 image: directed frames plus a random
// pixel/gap/reset stream, checked every cycle against a frame-array model.
module tb_line_buffer_3x3;
  localparam int WI    = 8;
  localparam int IMG_W = 5;
  localparam int IMG_H = 4;
  localparam int RWD   = 3 * WI;
  localparam int NPIX  = IMG_W * IMG_H;

  localparam logic [3*RWD-1:0] LIT_A_FIRST = 72'h000102_101112_202122;
  localparam logic [3*RWD-1:0] LIT_A_LAST  = 72'h121314_222324_323334;
  localparam logic [3*RWD-1:0] LIT_B_FIRST = 72'h808182_909192_A0A1A2;
  localparam logic [3*RWD-1:0] LIT_B_LAST  = 72'h929394_A2A3A4_B2B3B4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [0:0] dbg_state;

  always #5 clk = ~clk;

  line_buffer_3x3_if #(.WI(WI)) bus_if ();

  line_buffer_3x3 #(.WI(WI), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .iClk      (clk),
    .iRst      (rst),
    .bus       (bus_if),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard / counters ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [3*RWD-1:0] exp_q [$];
  logic [3*RWD-1:0] seen_q [$];
  int done_cnt = 0;
  int done_at  = -1;

  task automatic chk(input string name, input logic [3*RWD-1:0] act,
                     input logic [3*RWD-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_seen(input string name, input int idx, input logic [3*RWD-1:0] lit);
    if (idx >= seen_q.size()) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got only %0d windows, required index %0d", name, seen_q.size(), idx);
    end else begin
      chk(name, seen_q[idx], lit);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The current frame is kept as a 2D array; a window is just a 3x3 slice of it.
  logic [WI-1:0]  img [IMG_H][IMG_W];
  int             m_n = 0;
  int             m_r, m_c;
  logic           m_valid = 1'b0;
  logic           m_done  = 1'b0;
  logic [RWD-1:0] m_r1 = '0, m_r2 = '0, m_r3 = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n     = 0;
      m_valid = 1'b0;
      m_done  = 1'b0;
      m_r1    = '0;
      m_r2    = '0;
      m_r3    = '0;
      exp_q.delete();
    end else begin
      m_valid = 1'b0;
      m_done  = 1'b0;
      if (bus_if.iInValid === 1'b1) begin
        m_r = m_n / IMG_W;
        m_c = m_n % IMG_W;
        img[m_r][m_c] = bus_if.iPixel;
        if (m_r >= 2 && m_c >= 2) begin
          m_valid = 1'b1;
          m_r1 = {img[m_r-2][m_c-2], img[m_r-2][m_c-1], img[m_r-2][m_c]};
          m_r2 = {img[m_r-1][m_c-2], img[m_r-1][m_c-1], img[m_r-1][m_c]};
          m_r3 = {img[m_r][m_c-2],   img[m_r][m_c-1],   img[m_r][m_c]};
          exp_q.push_back({m_r1, m_r2, m_r3});
        end
        m_done = (m_n == NPIX - 1);
        m_n = (m_n + 1) % NPIX;
      end
    end
  end

  // ---------------- compare process ----------------
  logic [3*RWD-1:0] got_w;

  always @(negedge clk) begin
    chk("out_valid", 72'(bus_if.oOutValid), 72'(m_valid));
    chk("row1_hold", 72'(bus_if.oWindowOutRow1), 72'(m_r1));
    chk("row2_hold", 72'(bus_if.oWindowOutRow2), 72'(m_r2));
    chk("row3_hold", 72'(bus_if.oWindowOutRow3), 72'(m_r3));
    if (bus_if.oOutValid === 1'b1) begin
      got_w = {bus_if.oWindowOutRow1, bus_if.oWindowOutRow2, bus_if.oWindowOutRow3};
      seen_q.push_back(got_w);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL window_unexpected: got %h with no window required (t=%0t)", got_w, $time);
      end else begin
        chk("window", got_w, exp_q.pop_front());
      end
    end
`ifdef LB_FRAME_DONE_EN
    chk("frame_done", 72'(bus_if.oFrameDone), 72'(m_done));
    if (bus_if.oFrameDone === 1'b1) begin
      done_cnt++;
      done_at = seen_q.size();
    end
`endif
  end

  // ---------------- driver tasks ----------------
  // Every task starts and ends 1 time unit after a rising edge.
  task automatic send(input logic [WI-1:0] p);
    bus_if.iInValid = 1'b1;
    bus_if.iPixel   = p;
    @(posedge clk);
    #1;
    bus_if.iInValid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [WI-1:0] base, input bit gapped);
    logic [WI-1:0] p;
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        p = base + WI'(r * 16 + c);
        send(p);
        if (gapped) idle(1);
      end
    end
  endtask

  task automatic begin_scn();
    seen_q.delete();
    done_cnt = 0;
    done_at  = -1;
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus_if.iInValid = 1'b0;
    bus_if.iPixel   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 72'(bus_if.oOutValid), 72'(0));
    chk("reset_rows", {bus_if.oWindowOutRow1, bus_if.oWindowOutRow2, bus_if.oWindowOutRow3}, 72'(0));
    chk("reset_state", 72'(dbg_state), 72'(0));
    rst = 1'b0;
    idle(2);

    // Basic frame, continuous valid.
    begin_scn();
    send_frame(8'h00, 1'b0);
    idle(2);
    chk("basic_count", 72'(seen_q.size()), 72'(6));
    chk_seen("basic_first", 0, LIT_A_FIRST);
    chk_seen("basic_last", 5, LIT_A_LAST);
    chk("basic_state_after", 72'(dbg_state), 72'(0));
`ifdef LB_FRAME_DONE_EN
    chk("basic_done_count", 72'(done_cnt), 72'(1));
    chk("basic_done_align", 72'(done_at), 72'(6));
`endif

    // Same frame with a gap after every pixel.
    begin_scn();
    send_frame(8'h00, 1'b1);
    idle(2);
    chk("gapped_count", 72'(seen_q.size()), 72'(6));
    chk_seen("gapped_first", 0, LIT_A_FIRST);
    chk_seen("gapped_last", 5, LIT_A_LAST);

    // Two frames back to back.
    begin_scn();
    send_frame(8'h00, 1'b0);
    send_frame(8'h80, 1'b0);
    idle(2);
    chk("b2b_count", 72'(seen_q.size()), 72'(12));
    chk_seen("b2b_first_frame_last", 5, LIT_A_LAST);
    chk_seen("b2b_second_first", 6, LIT_B_FIRST);
    chk_seen("b2b_second_last", 11, LIT_B_LAST);
`ifdef LB_FRAME_DONE_EN
    chk("b2b_done_count", 72'(done_cnt), 72'(2));
`endif

    // Reset after pixel (2,3), then restart the frame.
    begin_scn();
    for (int i = 0; i <= 2 * IMG_W + 3; i++) send(WI'((i / IMG_W) * 16 + (i % IMG_W)));
    chk("pre_reset_valid", 72'(bus_if.oOutValid), 72'(1));
    #2 rst = 1'b1;
    #1;
    chk("mid_reset_valid", 72'(bus_if.oOutValid), 72'(0));
    chk("mid_reset_rows", {bus_if.oWindowOutRow1, bus_if.oWindowOutRow2, bus_if.oWindowOutRow3}, 72'(0));
    chk("mid_reset_state", 72'(dbg_state), 72'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    begin_scn();
    send_frame(8'h00, 1'b0);
    idle(2);
    chk("restart_count", 72'(seen_q.size()), 72'(6));
    chk_seen("restart_first", 0, LIT_A_FIRST);

    // Random pixels, random gaps, one random mid-stream reset.
    begin_scn();
    begin
      int rst_at;
      rst_at = $urandom_range(NPIX + 3, 2 * NPIX - 3);
      for (int i = 0; i < 4 * NPIX + 7; i++) begin
        if (i == rst_at) pulse_reset();
        send(WI'($urandom_range(0, 255)));
        idle($urandom_range(0, 2));
      end
    end
    idle(3);
    chk("exp_q_drained", 72'(exp_q.size()), 72'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
